i2s_adc_receiver: RTL and testbench
===================================

# i2s_adc_receiver

- Front-end stage feeding the IIR filter chain.
- Deserialises the 24-bit stereo I2S stream from the external ADC. The ADC clocks are oversampled in the system clock domain.
- Presents each completed stereo frame as two signed samples plus a one-cycle `valid_o` strobe. `valid_o` drives the filter's `start_i`, and `left_o`/`right_o` drive `signal_i` directly.

## Interface
- `BITWIDTH`, default 24: sample width. Bits captured per slot, MSB first.
- `MAX_SLOT_BITS`, default 32: maximum SCLK rises per slot. A slot longer than this is a framing error.

Ports:
- `clk_i`, in, 1: system clock. Must be at least 8× SCLK.
- `reset_ni`, in, 1: reset, asynchronous assert, active-low.
- `sclk_i`, in, 1: I2S bit clock, asynchronous to `clk_i`.
- `lrclk_i`, in, 1: I2S word select. 0 = left, 1 = right. Asynchronous.
- `sdata_i`, in, 1: I2S serial data. Asynchronous.
- `left_o`, out, `BITWIDTH`, signed: last complete left sample.
- `right_o`, out, `BITWIDTH`, signed: last complete right sample.
- `valid_o`, out, 1: one-cycle pulse; `left_o`/`right_o` updated this cycle.
- `frame_err_o`, out, 1: one-cycle pulse; frame discarded.
- `locked_o`, out, 1: high after the first valid frame. Cleared by reset or a framing error.

## Operation
- **Synchronisation:** `sclk_i`, `lrclk_i` and `sdata_i` each pass a 2-FF synchroniser. A rising-edge detector on the synchronised SCLK produces `bit_stb`, one cycle wide.
- **Sampling:** on each `bit_stb`, sample the synchronised `lrclk` and `sdata`. All state below advances only on `bit_stb`.
- **Word-select change:** a sampled `lrclk` differing from the previous sampled value marks a slot boundary.
  - The data bit on the boundary strobe is the I2S one-bit delay position. It is ignored.
  - The slot bit counter clears to 0.
- **Capture:** on later strobes, while counter < `BITWIDTH`, shift `sdata` into the slot shift register, MSB first. The counter increments on every strobe and saturates at `MAX_SLOT_BITS`+1. Bits beyond `BITWIDTH` are padding and are discarded.
- **State machine, states SYNC / LEFT / RIGHT:**
  - SYNC: waits for a boundary with `lrclk`=0, then goes to LEFT. Nothing captured before this is ever output.
  - LEFT, at the boundary to `lrclk`=1:
    - slot good: latch the shift register into a left holding register and go to RIGHT;
    - slot bad: pulse `frame_err_o` and go to SYNC.
  - RIGHT, at the boundary to `lrclk`=0:
    - slot good: load `left_o` from the holding register and `right_o` from the shift register; pulse `valid_o`; set `locked_o`; go to LEFT;
    - slot bad: pulse `frame_err_o`, clear `locked_o`, go to SYNC.
- **Slot good / bad:** a slot is good only if its counter lies in [`BITWIDTH`, `MAX_SLOT_BITS`] at the boundary.
- **Overlong slot:** if the counter exceeds `MAX_SLOT_BITS` mid-slot (stuck LRCLK), pulse `frame_err_o` once, clear `locked_o`, go to SYNC.
- **Bad frames:** `left_o`/`right_o` hold their previous values and never show partial or mixed-frame data.
- **Stopped SCLK:** no strobes, no state change, outputs hold. No timeout.

## Timing
- **Reset values:** state SYNC, `left_o`=0, `right_o`=0, `valid_o`=0, `frame_err_o`=0, `locked_o`=0, counters and shift register 0, synchronisers 0.
- **Reset mid-frame:** the partial frame is discarded and the block resynchronises from SYNC.
- **Latency:**
  - `bit_stb` asserts 3 `clk_i` cycles after an SCLK rising edge at the pin: 2 sync stages plus 1 edge register.
  - `valid_o`/`frame_err_o` assert on the `clk_i` edge following the boundary `bit_stb`.
- **Strobe spacing:**
  - `valid_o` fires at most once per stereo frame, at least 2·`BITWIDTH`+2 strobes apart.
  - `valid_o` and `frame_err_o` are never high in the same cycle.
- **No back-pressure:** the consumer must accept `valid_o` on the pulse. The filter start-on-strobe semantics satisfy this.
- **Setup requirement:** `lrclk_i` and `sdata_i` change on SCLK falling edges only. With `clk_i` ≥ 8× SCLK, they are stable at every `bit_stb`.

## Structure
- **Package `i2s_pkg`** holds:
  - the state enum `i2s_state_e` {SYNC, LEFT, RIGHT};
  - `DEFAULT_BITWIDTH`=24 and `DEFAULT_MAX_SLOT_BITS`=32;
  - the counter width, `$clog2(MAX_SLOT_BITS+2)`.
- **Sub-module `input_synchronizer`:** parameterised-width 2-FF synchroniser with optional rising-edge output. Instantiated once for 3 bits, with the edge output used on the SCLK bit. Reused elsewhere for asynchronous inputs.
- **Top level:** bit counter, shift register, holding register and state machine in one file, roughly 200 lines.

## Test plan
- **Nominal frame:** `clk_i`=100 MHz, SCLK=3.125 MHz (64 fs), 32-bit slots, frames L=0x7FFFFF, R=0x800000 after one sync frame. Expected: `valid_o` with `left_o`=8388607, `right_o`=-8388608, `locked_o`=1. `valid_o` lands 1 cycle after the boundary strobe.
- **Back-to-back frames:** L=0x123456/R=0xFFFFFF, then L=0x000001/R=0xEDCBA9. Expected: exactly two `valid_o` pulses with the matching values. No `frame_err_o`.
- **Start mid-slot:** stream starts in the middle of a right slot. Expected: no output until the first full L+R frame. The first `valid_o` carries the second frame's values.
- **Short slot:** a left slot of only 16 SCLKs. Expected: `frame_err_o` pulse, no `valid_o`, `locked_o`=0, outputs unchanged. The next good frame gives `valid_o` with the correct values.
- **Stuck LRCLK:** LRCLK held high for 40 SCLKs. Expected: a single `frame_err_o` pulse on the 33rd strobe, then recovery on a good frame.
- **Reset mid-frame:** assert `reset_ni` low for 3 cycles, asynchronous to `clk_i`, mid left slot. Expected: all outputs read 0 immediately. No `valid_o` until one full frame after the next LRCLK falling boundary.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S ADC receiver front end.
package i2s_pkg;

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_state_e;

  localparam int unsigned DEFAULT_BITWIDTH      = 24;
  localparam int unsigned DEFAULT_MAX_SLOT_BITS = 32;

  // The slot counter must be able to hold its saturation value MAX_SLOT_BITS+1.
  function automatic int unsigned cnt_width(input int unsigned max_slot_bits);
    return $clog2(max_slot_bits + 2);
  endfunction

  localparam int unsigned DEFAULT_CNT_WIDTH = cnt_width(DEFAULT_MAX_SLOT_BITS);

endpackage

// File: rtl/input_synchronizer.sv
// Parameterised-width 2-FF synchroniser for asynchronous inputs, with an optional
// registered rising-edge pulse on one selected bit.
module input_synchronizer #(
  parameter int unsigned WIDTH    = 1,
  parameter bit          EDGE_EN  = 1'b0,
  parameter int unsigned EDGE_IDX = 0
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             rise_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

  if (EDGE_EN) begin : g_edge
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        prev_q <= 1'b0;
        rise_q <= 1'b0;
      end else begin
        prev_q <= sync_q[EDGE_IDX];
        rise_q <= sync_q[EDGE_IDX] & ~prev_q;
      end
    end

    assign rise_o = rise_q;
  end else begin : g_no_edge
    assign rise_o = 1'b0;
  end

endmodule

// File: rtl/i2s_adc_receiver.sv
// Deserialises a stereo I2S stream (oversampled in clk_i) into signed left/right
// samples with a one-cycle valid strobe; bad slots are discarded with frame_err_o.
module i2s_adc_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned BITWIDTH      = DEFAULT_BITWIDTH,
  parameter int unsigned MAX_SLOT_BITS = DEFAULT_MAX_SLOT_BITS
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       sclk_i,
  input  logic                       lrclk_i,
  input  logic                       sdata_i,
  output logic signed [BITWIDTH-1:0] left_o,
  output logic signed [BITWIDTH-1:0] right_o,
  output logic                       valid_o,
  output logic                       frame_err_o,
  output logic                       locked_o
);

  localparam int unsigned CntW = cnt_width(MAX_SLOT_BITS);

  localparam logic [CntW-1:0] CntMin = CntW'(BITWIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_SLOT_BITS);
  localparam logic [CntW-1:0] CntSat = CntW'(MAX_SLOT_BITS + 1);

  logic [2:0]          sync_q;
  logic                bit_stb;
  logic                lrclk_s;
  logic                sdata_s;
  logic                unused_sclk_sync;
  logic                boundary;
  logic                slot_good;

  i2s_state_e          state_q;
  logic                lr_prev_q;
  logic [CntW-1:0]     cnt_q;
  logic [BITWIDTH-1:0] shift_q;
  logic [BITWIDTH-1:0] hold_q;

  input_synchronizer #(
    .WIDTH   (3),
    .EDGE_EN (1'b1),
    .EDGE_IDX(0)
  ) u_sync (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .d_i     ({sdata_i, lrclk_i, sclk_i}),
    .q_o     (sync_q),
    .rise_o  (bit_stb)
  );

  assign unused_sclk_sync = sync_q[0];
  assign lrclk_s          = sync_q[1];
  assign sdata_s          = sync_q[2];

  assign boundary  = (lrclk_s != lr_prev_q);
  assign slot_good = (cnt_q >= CntMin) && (cnt_q <= CntMax);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= SYNC;
      lr_prev_q   <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      left_o      <= '0;
      right_o     <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      locked_o    <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      if (bit_stb) begin
        lr_prev_q <= lrclk_s;
        if (boundary) begin
          // The bit on the boundary strobe is the I2S one-bit delay slot: ignored.
          cnt_q   <= '0;
          shift_q <= '0;
          unique case (state_q)
            SYNC: begin
              if (!lrclk_s) state_q <= LEFT;
            end
            LEFT: begin
              if (slot_good) begin
                hold_q  <= shift_q;
                state_q <= RIGHT;
              end else begin
                frame_err_o <= 1'b1;
                locked_o    <= 1'b0;
                state_q     <= SYNC;
              end
            end
            RIGHT: begin
              if (slot_good) begin
                left_o   <= $signed(hold_q);
                right_o  <= $signed(shift_q);
                valid_o  <= 1'b1;
                locked_o <= 1'b1;
                state_q  <= LEFT;
              end else begin
                frame_err_o <= 1'b1;
                locked_o    <= 1'b0;
                state_q     <= SYNC;
              end
            end
            default: state_q <= SYNC;
          endcase
        end else begin
          if (cnt_q < CntMin) shift_q <= {shift_q[BITWIDTH-2:0], sdata_s};
          if (cnt_q != CntSat) cnt_q <= cnt_q + CntW'(1);
          // Stuck word select: flag once as the counter crosses MAX_SLOT_BITS.
          if ((cnt_q == CntMax) && (state_q != SYNC)) begin
            frame_err_o <= 1'b1;
            locked_o    <= 1'b0;
            state_q     <= SYNC;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Scoreboard bench for i2s_adc_receiver: frames are pushed when sent and popped
// when valid_o fires; framing errors are checked against the slot bit position.
module tb_i2s_adc_receiver;

  logic               clk;
  logic               reset_ni;
  logic               sclk;
  logic               lrclk;
  logic               sdata;
  logic signed [23:0] left_o;
  logic signed [23:0] right_o;
  logic               valid_o;
  logic               frame_err_o;
  logic               locked_o;

  int          n_checks;
  int          n_errors;
  int          n_valid;
  int          n_err;
  int          n_pushed;
  int          n_err_exp;
  int          slot_rise;
  int          err_rise_exp;
  time         last_rise;
  longint      last_l;
  longint      last_r;
  logic [47:0] exp_q[$];
  logic [47:0] e;

  i2s_adc_receiver #(
    .BITWIDTH     (24),
    .MAX_SLOT_BITS(32)
  ) dut (
    .clk_i      (clk),
    .reset_ni   (reset_ni),
    .sclk_i     (sclk),
    .lrclk_i    (lrclk),
    .sdata_i    (sdata),
    .left_o     (left_o),
    .right_o    (right_o),
    .valid_o    (valid_o),
    .frame_err_o(frame_err_o),
    .locked_o   (locked_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_left"}, left_o, 0);
    check_eq({tag, "_right"}, right_o, 0);
    check_eq({tag, "_valid"}, valid_o, 0);
    check_eq({tag, "_err"}, frame_err_o, 0);
    check_eq({tag, "_locked"}, locked_o, 0);
  endtask

  // Bit 0 is the delay position; bits 1..24 carry the sample MSB first; rest is padding.
  task automatic send_slot(input logic lr, input logic [23:0] smp, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      logic d;
      if (i >= 1 && i <= 24) d = smp[24-i];
      else d = 1'($urandom);
      sclk  = 1'b0;
      lrclk = lr;
      sdata = d;
      #160;
      sclk      = 1'b1;
      slot_rise = i + 1;
      last_rise = $time;
      #160;
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
    exp_q.push_back({l, r});
    n_pushed++;
  endtask

  always @(negedge clk) begin
    if (reset_ni) begin
      if (valid_o || frame_err_o) check_eq("excl", longint'(valid_o && frame_err_o), 0);
      if (valid_o) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check_eq("valid_unexp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          last_l = longint'($signed(e[47:24]));
          last_r = longint'($signed(e[23:0]));
          check_eq("valid_left", left_o, last_l);
          check_eq("valid_right", right_o, last_r);
        end
        check_eq("valid_locked", locked_o, 1);
        check_eq("valid_lat", longint'($time - last_rise), 43);
      end
      if (frame_err_o) begin
        n_err++;
        check_eq("err_pos", slot_rise, err_rise_exp);
        check_eq("err_left_hold", left_o, last_l);
        check_eq("err_right_hold", right_o, last_r);
        check_eq("err_locked", locked_o, 0);
      end
    end
  end

  initial begin
    n_checks = 0; n_errors = 0; n_valid = 0; n_err = 0; n_pushed = 0; n_err_exp = 0;
    slot_rise = 0; err_rise_exp = -1; last_rise = 0; last_l = 0; last_r = 0;
    reset_ni = 1'b0; sclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    #40;
    check_zero("reset");
    #12 reset_ni = 1'b1;
    #55;  // stimulus edges land 2 ns after a clk rising edge

    // Sync frame, then nominal and back-to-back frames.
    send_slot(1'b0, 24'h000000, 32);
    send_slot(1'b1, 24'h000000, 32);
    send_frame(24'h7FFFFF, 24'h800000);
    send_frame(24'h123456, 24'hFFFFFF);
    send_frame(24'h000001, 24'hEDCBA9);

    // Short left slot.
    send_slot(1'b0, 24'h0ABCDE, 16);
    err_rise_exp = 1;
    n_err_exp++;
    send_slot(1'b1, 24'h000000, 32);
    send_frame(24'h55AA55, 24'h2468AC);

    // Stuck LRCLK high for 40 SCLKs in the right slot.
    send_slot(1'b0, 24'h13579B, 32);
    err_rise_exp = 34;
    n_err_exp++;
    send_slot(1'b1, 24'h000000, 40);
    send_frame(24'h600000, 24'h0FEDCB);
    send_frame(24'h3C3C3C, 24'h4D4D4D);

    // Reset mid left slot.
    fork
      send_slot(1'b0, 24'h333333, 32);
      begin
        #5121;
        reset_ni = 1'b0;
        #1;
        check_zero("reset_mid");
        last_l = 0;
        last_r = 0;
        #29 reset_ni = 1'b1;
      end
    join
    send_slot(1'b1, 24'h000000, 32);
    send_frame(24'h7A7A7A, 24'h1B1B1B);
    send_slot(1'b0, 24'h000000, 32);

    // Restart mid right slot after a reset.
    reset_ni = 1'b0;
    #1;
    check_eq("reset2_locked", locked_o, 0);
    last_l = 0;
    last_r = 0;
    #29 reset_ni = 1'b1;
    #290;
    send_slot(1'b1, 24'h000000, 12);
    send_frame(24'h0F0F0F, 24'h707070);
    send_slot(1'b0, 24'h000000, 32);

    #2000;
    check_eq("valid_count", n_valid, n_pushed);
    check_eq("err_count", n_err, n_err_exp);
    check_eq("queue_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
